// File: rtl/grid_loader.sv
// Purpose: turns an ASCII '@' / '.' / newline stream into a 0/1 occupancy grid and checks line widths and bounds.
// Latency: each accepted byte updates state on its accepting edge; grid_valid/err are visible the following cycle.
// Backpressure: in_ready is high only while loading and clear is low; the loader holds in DONE/ERR until clear or reset.
module grid_loader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic [7:0]                   in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [WIDTH*DEPTH-1:0]       grid,
    output logic                         grid_valid,
    output logic [$clog2(DEPTH+1)-1:0]   n_rows,
    output logic [$clog2(WIDTH+1)-1:0]   n_cols,
    output logic                         err,
    output logic [1:0]                   err_code
);

    localparam int RW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH * DEPTH > 1) ? $clog2(WIDTH * DEPTH) : 1;

    localparam logic [RW-1:0] ROW_MAX = RW'(DEPTH);
    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH);

    localparam logic [7:0] CH_AT = 8'h40;
    localparam logic [7:0] CH_DOT = 8'h2E;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_CHAR = 2'd1;
    localparam logic [1:0] CODE_WIDTH = 2'd2;
    localparam logic [1:0] CODE_ROWS = 2'd3;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        DONE = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [RW-1:0]            row, row_nxt;
    logic [CW-1:0]            col, col_nxt;
    logic [CW-1:0]            ncols, ncols_nxt;
    logic                     width_latched, width_latched_nxt;
    logic [1:0]               code, code_nxt;
    logic [WIDTH*DEPTH-1:0]   grid_q, grid_nxt;
    logic [1:0]               fault;
    logic [IW-1:0]            cell_idx;

    // Flat bit position of the cell the next '@'/'.' lands in; only used once row/col are known in range.
    assign cell_idx = IW'(row) * IW'(WIDTH) + IW'(col);

    assign in_ready   = (state == LOAD) && !clear;
    assign grid       = grid_q;
    assign grid_valid = (state == DONE);
    assign err        = (state == ERR);
    assign err_code   = code;
    assign n_rows     = row;
    assign n_cols     = ncols;

    // State register for the load / done / error sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Position counters, latched width, error code and grid storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row           <= '0;
            col           <= '0;
            ncols         <= '0;
            width_latched <= 1'b0;
            code          <= CODE_NONE;
            grid_q        <= '0;
        end else begin
            row           <= row_nxt;
            col           <= col_nxt;
            ncols         <= ncols_nxt;
            width_latched <= width_latched_nxt;
            code          <= code_nxt;
            grid_q        <= grid_nxt;
        end
    end

    // Decode each accepted byte, then apply the implicit final newline when in_last closes a partial row.
    always_comb begin
        state_nxt         = state;
        row_nxt           = row;
        col_nxt           = col;
        ncols_nxt         = ncols;
        width_latched_nxt = width_latched;
        code_nxt          = code;
        grid_nxt          = grid_q;
        fault             = CODE_NONE;

        if (clear) begin
            state_nxt         = LOAD;
            row_nxt           = '0;
            col_nxt           = '0;
            ncols_nxt         = '0;
            width_latched_nxt = 1'b0;
            code_nxt          = CODE_NONE;
            grid_nxt          = '0;
        end else if (state == LOAD && in_valid) begin
            case (in_data)
                CH_AT, CH_DOT: begin
                    if (row == ROW_MAX) begin
                        fault = CODE_ROWS;
                    end else if (col == COL_MAX || (width_latched && col == ncols)) begin
                        fault = CODE_WIDTH;
                    end else begin
                        grid_nxt[cell_idx] = (in_data == CH_AT);
                        col_nxt            = col + 1'b1;
                    end
                end
                CH_LF: begin
                    // A newline at column 0 is a blank or trailing line and is skipped.
                    if (col != '0) begin
                        if (!width_latched) begin
                            ncols_nxt         = col;
                            width_latched_nxt = 1'b1;
                            row_nxt           = row + 1'b1;
                            col_nxt           = '0;
                        end else if (col != ncols) begin
                            fault = CODE_WIDTH;
                        end else begin
                            row_nxt = row + 1'b1;
                            col_nxt = '0;
                        end
                    end
                end
                CH_CR: begin
                    // Carriage returns from CRLF text carry no position information.
                end
                default: begin
                    fault = CODE_CHAR;
                end
            endcase

            if (fault != CODE_NONE) begin
                state_nxt = ERR;
                code_nxt  = fault;
            end else if (in_last) begin
                if (col_nxt != '0) begin
                    if (width_latched_nxt && col_nxt != ncols_nxt) begin
                        state_nxt = ERR;
                        code_nxt  = CODE_WIDTH;
                    end else begin
                        if (!width_latched_nxt) begin
                            ncols_nxt         = col_nxt;
                            width_latched_nxt = 1'b1;
                        end
                        row_nxt   = row_nxt + 1'b1;
                        col_nxt   = '0;
                        state_nxt = DONE;
                    end
                end else begin
                    state_nxt = DONE;
                end
            end
        end
    end

endmodule
